// File: rtl/pwm_un_driver.sv
// PWM driver for a half-bridge: captures the PID output u(n), scales and
// clamps it to a duty value, and generates complementary high/low gate
// drives with dead time inserted at every switch-over.
module pwm_un_driver #(
    parameter int unsigned cnt_nb    = 10,
    parameter int unsigned un_shift  = 4,
    parameter int unsigned dead_time = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [31:0]       i_un,
    input  logic              i_valid,
    input  logic [cnt_nb-1:0] i_period,
    input  logic              i_en,
    output logic              o_pwm_h,
    output logic              o_pwm_l,
    output logic [cnt_nb-1:0] o_duty,
    output logic              o_sat,
    output logic              o_sync
);

    localparam int unsigned UW = 32;
    localparam int unsigned CW = cnt_nb;
    localparam int unsigned DW = (dead_time > 1) ? $clog2(dead_time) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = (dead_time > 0) ? DW'(dead_time - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DEAD = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Capture stage
    // ------------------------------------------------------------------
    logic          valid_q;
    logic [UW-1:0] un_q;
    logic          cap_q;
    logic          cap_c;

    assign cap_c = i_valid & ~valid_q;

    // Latch u(n) on the rising edge of the PID valid flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b1;
            un_q    <= '0;
            cap_q   <= 1'b0;
        end else begin
            valid_q <= i_valid;
            cap_q   <= cap_c;
            if (cap_c) begin
                un_q <= i_un;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scale / clamp
    // ------------------------------------------------------------------
    logic signed [UW-1:0] s_c;
    logic [CW-1:0]        scaled_c;
    logic                 scaled_sat_c;

    assign s_c = $signed(un_q) >>> un_shift;

    // Clamp the shifted value into [0, i_period]
    always_comb begin
        scaled_c     = s_c[CW-1:0];
        scaled_sat_c = 1'b0;
        if (s_c[UW-1]) begin
            scaled_c     = '0;
            scaled_sat_c = 1'b1;
        end else if (UW'(s_c) > UW'(i_period)) begin
            scaled_c     = i_period;
            scaled_sat_c = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_c;

    assign wrap_c = i_en && (cnt_q >= i_period);

    // Free-running counter, held at zero while disabled
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!i_en || wrap_c) begin
            cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Pending duty and boundary load
    // ------------------------------------------------------------------
    logic          pend_q, pend_d;
    logic [CW-1:0] duty_pend_q, duty_pend_d;
    logic [CW-1:0] duty_q, duty_d;
    logic          sat_q, sat_d;
    logic          sync_q;
    logic          load_c;

    assign load_c = pend_q && (wrap_c || !i_en);

    // Apply a pending duty at the period boundary (or at once when disabled)
    always_comb begin
        pend_d      = pend_q;
        duty_pend_d = duty_pend_q;
        duty_d      = duty_q;
        sat_d       = sat_q;
        if (load_c) begin
            duty_d = duty_pend_q;
            pend_d = 1'b0;
        end
        if (cap_q) begin
            duty_pend_d = scaled_c;
            sat_d       = scaled_sat_c;
            pend_d      = 1'b1;
        end
    end

    // Counter, duty and sync registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            duty_pend_q <= '0;
            duty_q      <= '0;
            sat_q       <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            duty_pend_q <= duty_pend_d;
            duty_q      <= duty_d;
            sat_q       <= sat_d;
            sync_q      <= wrap_c;
        end
    end

    // ------------------------------------------------------------------
    // Gate-drive FSM with dead time
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          pwm_h_q, pwm_l_q;
    logic          raw_c;

    assign raw_c = (cnt_q < duty_q);

    // Next state: follow raw, inserting a dead interval at each switch
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (!i_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = raw_c ? HI : LO;
                HI: begin
                    if (!raw_c) begin
                        if (dead_time == 0) begin
                            state_d = LO;
                        end else begin
                            state_d = DEAD;
                            dcnt_d  = DEAD_LOAD;
                        end
                    end
                end
                LO: begin
                    if (raw_c) begin
                        if (dead_time == 0) begin
                            state_d = HI;
                        end else begin
                            state_d = DEAD;
                            dcnt_d  = DEAD_LOAD;
                        end
                    end
                end
                DEAD: begin
                    if (dcnt_q == '0) begin
                        state_d = raw_c ? HI : LO;
                    end else begin
                        dcnt_d = dcnt_q - DW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with gate outputs registered alongside it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            pwm_h_q <= (state_d == HI);
            pwm_l_q <= (state_d == LO);
        end
    end

    assign o_pwm_h = pwm_h_q;
    assign o_pwm_l = pwm_l_q;
    assign o_duty  = duty_q;
    assign o_sat   = sat_q;
    assign o_sync  = sync_q;

endmodule

// File: tb/tb_pwm_un_driver.sv
// Self-checking bench for pwm_un_driver: directed and random u(n) updates,
// scoreboard of expected duty/saturation at each period start, and
// steady-state gate pulse widths derived from the duty and dead time.
module tb_pwm_un_driver;

    localparam int P  = 99;
    localparam int N  = P + 1;
    localparam int DT = 3;
    localparam int SH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] un;
    logic        valid;
    logic [9:0]  period;
    logic        en;
    logic        pwm_h, pwm_l;
    logic [9:0]  duty;
    logic        sat, sync;

    always #5 clk = ~clk;

    pwm_un_driver #(.cnt_nb(10), .un_shift(SH), .dead_time(DT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_un    (un),
        .i_valid (valid),
        .i_period(period),
        .i_en    (en),
        .o_pwm_h (pwm_h),
        .o_pwm_l (pwm_l),
        .o_duty  (duty),
        .o_sat   (sat),
        .o_sync  (sync)
    );

    typedef struct {
        int duty;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   overlap_err = 0;
    int   midchg_err  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: floor(u/2^SH), then clamp to [0, P]
    function automatic void model(input logic [31:0] u, output int d, output bit s);
        longint v;
        longint div;
        div = longint'(1) << SH;
        v = longint'($signed(u));
        if (v < 0) v = -((-v + div - 1) / div);
        else       v = v / div;
        if (v < 0)      begin d = 0; s = 1'b1; end
        else if (v > P) begin d = P; s = 1'b1; end
        else            begin d = int'(v); s = 1'b0; end
    endfunction

    // Steady-state per-period gate widths for a given duty
    function automatic void widths(input int d, output int h, output int l);
        int lo;
        lo = N - d;
        if (d == 0)                begin h = 0;      l = N;      end
        else if (d <= DT)          begin h = 0;      l = N - DT; end
        else if (lo <= DT)         begin h = N - DT; l = 0;      end
        else                       begin h = d - DT; l = lo - DT; end
    endfunction

    // Monitor: checks duty/sat at every period start and pulse widths
    initial begin : monitor
        int   h_cnt, l_cnt, start_duty, run, run_duty, prev_duty;
        int   eh, el, exp_duty;
        bit   have_start, prev_ok, exp_sat;
        exp_t e;
        h_cnt = 0; l_cnt = 0; start_duty = 0; run = 0; run_duty = -1;
        prev_duty = 0; have_start = 0; prev_ok = 0; exp_duty = 0; exp_sat = 0;
        forever begin
            @(negedge clk);
            if (pwm_h && pwm_l) overlap_err++;
            if (rst_n && en && prev_ok && int'(duty) != prev_duty && !sync) midchg_err++;
            prev_ok   = rst_n && en;
            prev_duty = int'(duty);
            if (!rst_n || !en) begin
                have_start = 0;
                run        = 0;
            end else if (sync) begin
                if (have_start) begin
                    run = (run > 0 && start_duty == run_duty) ? run + 1 : 1;
                    run_duty = start_duty;
                    if (run >= 2) begin
                        widths(start_duty, eh, el);
                        chk("h_width", h_cnt, eh);
                        chk("l_width", l_cnt, el);
                    end
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_duty = e.duty;
                    exp_sat  = e.sat;
                end
                chk("duty_at_sync", duty, exp_duty);
                chk("sat_at_sync", sat, exp_sat);
                have_start = 1;
                start_duty = int'(duty);
                h_cnt = 0;
                l_cnt = 0;
            end
            if (have_start) begin
                h_cnt += int'(pwm_h);
                l_cnt += int'(pwm_l);
            end
        end
    end

    task automatic wait_sync();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clk);
            if (sync) begin seen = 1; break; end
        end
        if (!seen) chk("sync_timeout", 0, 1);
    endtask

    // One rising edge of valid carrying value u
    task automatic issue(input logic [31:0] u);
        valid = 1'b0;
        @(negedge clk);
        un = u;
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] u1, input bit two, input logic [31:0] u2);
        exp_t e;
        repeat (5) @(negedge clk);
        issue(u1);
        if (two) issue(u2);
        model(two ? u2 : u1, e.duty, e.sat);
        exp_q.push_back(e);
    endtask

    logic [31:0] dir_a [12];
    logic [31:0] dir_b [12];
    bit          dir_two [12];

    initial begin : stim
        exp_t        e;
        logic [31:0] r1, r2;
        int          n, cat;
        bit          seen;

        dir_a = '{32'h0000_0320, 32'hFFFF_FF00, 32'h0001_0000, 32'h0000_0190,
                  32'd1599,      32'd1600,      32'h0000_000F, 32'hFFFF_FFFF,
                  32'h0000_0030, 32'h0000_0040, 32'h0000_0600, 32'h0000_0610};
        dir_b = '{default: 32'h0};
        dir_b[3] = 32'h0000_0320;
        dir_two = '{default: 1'b0};
        dir_two[3] = 1'b1;

        rst_n = 1'b0; en = 1'b0; valid = 1'b1; un = '0; period = 10'(P);
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pwm_h", pwm_h, 0);
        chk("rst_pwm_l", pwm_l, 0);
        chk("rst_duty",  duty,  0);
        chk("rst_sat",   sat,   0);
        chk("rst_sync",  sync,  0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_duty", duty, 0);
        chk("post_rst_sat",  sat,  0);

        for (int i = 0; i < 12; i++) begin
            wait_sync();
            send(dir_a[i], dir_two[i], dir_b[i]);
            repeat (3) wait_sync();
        end

        for (int i = 0; i < 14; i++) begin
            cat = int'($urandom_range(0, 3));
            case (cat)
                0:       r1 = 32'($urandom_range(0, 1700));
                1:       r1 = $urandom;
                2:       r1 = -32'($urandom_range(1, 500));
                default: r1 = 32'($urandom_range(1560, 1640));
            endcase
            r2 = 32'($urandom_range(0, 1600));
            wait_sync();
            send(r1, ($urandom_range(0, 3) == 0), r2);
            repeat (3) wait_sync();
        end

        // Disabled: outputs low, pending duty loads without a boundary
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("dis_pwm_h", pwm_h, 0);
        chk("dis_pwm_l", pwm_l, 0);
        issue(32'h0000_0100);
        repeat (3) @(negedge clk);
        model(32'h0000_0100, e.duty, e.sat);
        chk("dis_load_duty", duty, e.duty);
        chk("dis_load_sat",  sat,  e.sat);
        chk("dis_sync", sync, 0);
        exp_q.push_back(e);
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clk);
            n++;
            if (sync) break;
        end
        chk("restart_len", n, N);
        repeat (2) wait_sync();

        // Asynchronous reset while the high side is on
        seen = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clk);
            if (pwm_h) begin seen = 1; break; end
        end
        chk("pwm_h_seen", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("async_pwm_h", pwm_h, 0);
        chk("async_pwm_l", pwm_l, 0);
        chk("async_duty",  duty,  0);
        exp_q.delete();
        e.duty = 0; e.sat = 1'b0;
        exp_q.push_back(e);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_sync();
        send(32'h0000_0320, 1'b0, 32'h0);
        repeat (3) wait_sync();

        chk("no_overlap", overlap_err, 0);
        chk("no_mid_period_change", midchg_err, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
